// File: rtl/grf_commit_pkg.sv
// Shared types and constants for the write-back register file and its commit trace.
// Trace entries are packed {pc, a3, wd} with wd in the low bits.
package grf_commit_pkg;

    localparam logic [4:0] GRF_ZERO = 5'd0;

    localparam int TRACE_W   = 69;
    localparam int TR_WD_LSB = 0;
    localparam int TR_A3_LSB = 32;
    localparam int TR_PC_LSB = 37;

    function automatic logic [TRACE_W-1:0] pack_trace(input logic [31:0] pc,
                                                      input logic [4:0]  a3,
                                                      input logic [31:0] wd);
        logic [TRACE_W-1:0] e;
        e = '0;
        e[TR_PC_LSB +: 32] = pc;
        e[TR_A3_LSB +: 5]  = a3;
        e[TR_WD_LSB +: 32] = wd;
        return e;
    endfunction

endpackage

// File: rtl/grf_commit_if.sv
// W-stage write port, D-stage read/scoreboard ports and trace drain port of grf_commit.
// master drives the pipeline side; slave is the register file.
interface grf_commit_if;
    logic        W_GRF_WE;
    logic [4:0]  W_GRF_A3;
    logic [31:0] W_GRF_WD;
    logic [31:0] W_pc;
    logic [4:0]  D_GRF_A1;
    logic [4:0]  D_GRF_A2;
    logic [31:0] D_GRF_RD1;
    logic [31:0] D_GRF_RD2;
    logic        D_busy1;
    logic        D_busy2;
    logic        issue_we;
    logic [4:0]  issue_a3;
    logic        sb_flush;
    logic        trace_valid;
    logic        trace_ready;
    logic [31:0] trace_pc;
    logic [4:0]  trace_a3;
    logic [31:0] trace_wd;
    logic        trace_ovf;

    modport master (
        output W_GRF_WE, W_GRF_A3, W_GRF_WD, W_pc, D_GRF_A1, D_GRF_A2,
               issue_we, issue_a3, sb_flush, trace_ready,
        input  D_GRF_RD1, D_GRF_RD2, D_busy1, D_busy2,
               trace_valid, trace_pc, trace_a3, trace_wd, trace_ovf
    );

    modport slave (
        input  W_GRF_WE, W_GRF_A3, W_GRF_WD, W_pc, D_GRF_A1, D_GRF_A2,
               issue_we, issue_a3, sb_flush, trace_ready,
        output D_GRF_RD1, D_GRF_RD2, D_busy1, D_busy2,
               trace_valid, trace_pc, trace_a3, trace_wd, trace_ovf
    );
endinterface

// File: rtl/grf_trace_fifo.sv
// Synchronous FIFO with sticky overflow; push visible one cycle later (no fall-through).
// Pushing while full drops the entry and sets ovf unless a pop happens in the same cycle.
module grf_trace_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 69
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic             valid,
    output logic [WIDTH-1:0] dout,
    output logic             ovf
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [PW-1:0]    wr_ptr, rd_ptr;
    logic [PW-1:0]    count;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             empty, full, do_pop, do_push;

    assign count   = wr_ptr - rd_ptr;
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (count == PW'(DEPTH));
    assign do_pop  = !empty && pop;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            ovf    <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && full && !do_pop) ovf <= 1'b1;
        end
    end

    // Storage needs no reset: the head is masked to zero whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

    assign valid = !empty;
    assign dout  = empty ? '0 : mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/grf_commit.sv
// Architectural register file x1..x31 with write-through bypass reads and a pending-write scoreboard.
// Reads are combinational; writes, scoreboard and trace pushes land on the next edge.
// Commit trace FIFO is built only with GRF_TRACE_EN; drain via trace_valid/trace_ready, overflow is sticky.
module grf_commit
    import grf_commit_pkg::*;
#(
    parameter int TRACE_DEPTH = 8
) (
    input  logic         clk,
    input  logic         reset_n,
    grf_commit_if.slave  bus
);
    logic [31:0] regs [1:31];
    logic [31:0] busy, busy_nxt;
    logic [31:0] rd1, rd2;
    logic        write_ok;

    assign write_ok = bus.W_GRF_WE && (bus.W_GRF_A3 != GRF_ZERO);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 1; i < 32; i++) regs[i] <= '0;
        end else if (write_ok) begin
            regs[bus.W_GRF_A3] <= bus.W_GRF_WD;
        end
    end

    always_comb begin
        rd1 = '0;
        if (bus.D_GRF_A1 != GRF_ZERO)
            rd1 = (bus.W_GRF_WE && bus.W_GRF_A3 == bus.D_GRF_A1) ? bus.W_GRF_WD : regs[bus.D_GRF_A1];
    end

    always_comb begin
        rd2 = '0;
        if (bus.D_GRF_A2 != GRF_ZERO)
            rd2 = (bus.W_GRF_WE && bus.W_GRF_A3 == bus.D_GRF_A2) ? bus.W_GRF_WD : regs[bus.D_GRF_A2];
    end

    assign bus.D_GRF_RD1 = rd1;
    assign bus.D_GRF_RD2 = rd2;

    // Set after clear: a same-register issue belongs to the younger instruction.
    always_comb begin
        busy_nxt = busy;
        if (write_ok) busy_nxt[bus.W_GRF_A3] = 1'b0;
        if (bus.issue_we && bus.issue_a3 != GRF_ZERO) busy_nxt[bus.issue_a3] = 1'b1;
        if (bus.sb_flush) busy_nxt = '0;
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) busy <= '0;
        else          busy <= busy_nxt;
    end

    assign bus.D_busy1 = busy[bus.D_GRF_A1];
    assign bus.D_busy2 = busy[bus.D_GRF_A2];

`ifdef GRF_TRACE_EN
    logic [TRACE_W-1:0] trace_in, trace_head;
    logic               trace_vld, trace_ovf_q;

    assign trace_in = pack_trace(bus.W_pc, bus.W_GRF_A3, bus.W_GRF_WD);

    // x0 commits are logged as well; only the register write is suppressed.
    grf_trace_fifo #(
        .DEPTH (TRACE_DEPTH),
        .WIDTH (TRACE_W)
    ) u_trace_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (bus.W_GRF_WE),
        .din     (trace_in),
        .pop     (bus.trace_ready),
        .valid   (trace_vld),
        .dout    (trace_head),
        .ovf     (trace_ovf_q)
    );

    assign bus.trace_valid = trace_vld;
    assign bus.trace_ovf   = trace_ovf_q;
    assign bus.trace_pc    = trace_head[TR_PC_LSB +: 32];
    assign bus.trace_a3    = trace_head[TR_A3_LSB +: 5];
    assign bus.trace_wd    = trace_head[TR_WD_LSB +: 32];
`else
    logic unused_trace;
    assign unused_trace    = ^{bus.trace_ready, bus.W_pc, (TRACE_DEPTH > 0)};

    assign bus.trace_valid = 1'b0;
    assign bus.trace_ovf   = 1'b0;
    assign bus.trace_pc    = '0;
    assign bus.trace_a3    = '0;
    assign bus.trace_wd    = '0;
`endif

endmodule

// File: tb/tb_grf_commit.sv
// Directed bench for grf_commit: register file, bypass, scoreboard and (with GRF_TRACE_EN) trace FIFO.
module tb_grf_commit;
    logic clk;
    logic reset_n;
    int   n_checks;
    int   n_fail;

    grf_commit_if bus ();

    grf_commit #(.TRACE_DEPTH(8)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.W_GRF_WE    = 1'b0;
        bus.W_GRF_A3    = '0;
        bus.W_GRF_WD    = '0;
        bus.W_pc        = '0;
        bus.D_GRF_A1    = '0;
        bus.D_GRF_A2    = '0;
        bus.issue_we    = 1'b0;
        bus.issue_a3    = '0;
        bus.sb_flush    = 1'b0;
        bus.trace_ready = 1'b0;
    endtask

    task automatic commit(input logic [4:0] a3, input logic [31:0] wd, input logic [31:0] pc);
        bus.W_GRF_WE = 1'b1;
        bus.W_GRF_A3 = a3;
        bus.W_GRF_WD = wd;
        bus.W_pc     = pc;
    endtask

    task automatic test_reset();
        idle();
        reset_n = 1'b1;
        #2 reset_n = 1'b0;
        bus.D_GRF_A1 = 5'd5;
        bus.D_GRF_A2 = 5'd3;
        #3;
        n_checks++; if (bus.D_GRF_RD1 !== 32'h0) begin n_fail++; $display("FAIL reset_rd1: got %h expected %h", bus.D_GRF_RD1, 32'h0); end
        n_checks++; if (bus.D_busy2 !== 1'b0) begin n_fail++; $display("FAIL reset_busy2: got %b expected 0", bus.D_busy2); end
        n_checks++; if (bus.trace_valid !== 1'b0) begin n_fail++; $display("FAIL reset_trace_valid: got %b expected 0", bus.trace_valid); end
        n_checks++; if (bus.trace_ovf !== 1'b0) begin n_fail++; $display("FAIL reset_trace_ovf: got %b expected 0", bus.trace_ovf); end
        n_checks++; if (bus.trace_pc !== 32'h0) begin n_fail++; $display("FAIL reset_trace_pc: got %h expected %h", bus.trace_pc, 32'h0); end
        @(negedge clk) reset_n = 1'b1;
        tick();
    endtask

`ifdef GRF_TRACE_EN
    task automatic drain_trace();
        bus.trace_ready = 1'b1;
        for (int i = 0; i < 32; i++) begin
            if (!bus.trace_valid) break;
            tick();
        end
        n_checks++; if (bus.trace_valid !== 1'b0) begin n_fail++; $display("FAIL drain_timeout: valid %b expected 0", bus.trace_valid); end
        bus.trace_ready = 1'b0;
        #1;
    endtask
`endif

    task automatic test_write_read();
        idle();
        commit(5'd5, 32'h1234_5678, 32'h100);
        bus.D_GRF_A1 = 5'd0;
        bus.D_GRF_A2 = 5'd5;
        #1;
        n_checks++; if (bus.D_GRF_RD2 !== 32'h1234_5678) begin n_fail++; $display("FAIL bypass_rd2: got %h expected %h", bus.D_GRF_RD2, 32'h1234_5678); end
        n_checks++; if (bus.D_GRF_RD1 !== 32'h0) begin n_fail++; $display("FAIL rd1_x0: got %h expected %h", bus.D_GRF_RD1, 32'h0); end
        n_checks++; if (bus.trace_valid !== 1'b0) begin n_fail++; $display("FAIL no_fall_through: got %b expected 0", bus.trace_valid); end
        tick();
        bus.W_GRF_WE = 1'b0;
        bus.D_GRF_A1 = 5'd5;
        bus.D_GRF_A2 = 5'd6;
        #1;
        n_checks++; if (bus.D_GRF_RD1 !== 32'h1234_5678) begin n_fail++; $display("FAIL rd1_after_write: got %h expected %h", bus.D_GRF_RD1, 32'h1234_5678); end
        n_checks++; if (bus.D_GRF_RD2 !== 32'h0) begin n_fail++; $display("FAIL rd2_untouched: got %h expected %h", bus.D_GRF_RD2, 32'h0); end
`ifdef GRF_TRACE_EN
        n_checks++; if (bus.trace_valid !== 1'b1) begin n_fail++; $display("FAIL trace_latency: got %b expected 1", bus.trace_valid); end
        n_checks++; if (bus.trace_pc !== 32'h100) begin n_fail++; $display("FAIL trace_first_pc: got %h expected %h", bus.trace_pc, 32'h100); end
`endif
        // bypass must win over the stale stored value
        commit(5'd5, 32'hCAFE_F00D, 32'h104);
        #1;
        n_checks++; if (bus.D_GRF_RD1 !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL bypass_over_stored: got %h expected %h", bus.D_GRF_RD1, 32'hCAFE_F00D); end
        tick();
        idle();
    endtask

    task automatic test_x0();
        idle();
`ifdef GRF_TRACE_EN
        drain_trace();
`endif
        commit(5'd0, 32'hFFFF_FFFF, 32'h108);
        bus.trace_ready = 1'b1;
        bus.D_GRF_A1 = 5'd0;
        #1;
        n_checks++; if (bus.D_GRF_RD1 !== 32'h0) begin n_fail++; $display("FAIL x0_same_cycle: got %h expected %h", bus.D_GRF_RD1, 32'h0); end
`ifdef GRF_TRACE_EN
        bus.trace_ready = 1'b0;
`endif
        tick();
        bus.W_GRF_WE = 1'b0;
        #1;
        n_checks++; if (bus.D_GRF_RD1 !== 32'h0) begin n_fail++; $display("FAIL x0_next_cycle: got %h expected %h", bus.D_GRF_RD1, 32'h0); end
`ifdef GRF_TRACE_EN
        n_checks++; if (bus.trace_a3 !== 5'd0) begin n_fail++; $display("FAIL x0_trace_a3: got %h expected %h", bus.trace_a3, 5'd0); end
        n_checks++; if (bus.trace_wd !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL x0_trace_wd: got %h expected %h", bus.trace_wd, 32'hFFFF_FFFF); end
        n_checks++; if (bus.trace_pc !== 32'h108) begin n_fail++; $display("FAIL x0_trace_pc: got %h expected %h", bus.trace_pc, 32'h108); end
`else
        n_checks++; if (bus.trace_valid !== 1'b0) begin n_fail++; $display("FAIL tie_trace_valid: got %b expected 0", bus.trace_valid); end
        n_checks++; if (bus.trace_wd !== 32'h0) begin n_fail++; $display("FAIL tie_trace_wd: got %h expected %h", bus.trace_wd, 32'h0); end
        n_checks++; if (bus.trace_ovf !== 1'b0) begin n_fail++; $display("FAIL tie_trace_ovf: got %b expected 0", bus.trace_ovf); end
`endif
        idle();
    endtask

    task automatic test_scoreboard();
        idle();
        bus.issue_we = 1'b1;
        bus.issue_a3 = 5'd7;
        bus.D_GRF_A1 = 5'd7;
        #1;
        n_checks++; if (bus.D_busy1 !== 1'b0) begin n_fail++; $display("FAIL busy_not_yet: got %b expected 0", bus.D_busy1); end
        tick();
        bus.issue_we = 1'b0;
        #1;
        n_checks++; if (bus.D_busy1 !== 1'b1) begin n_fail++; $display("FAIL busy_set: got %b expected 1", bus.D_busy1); end
        bus.issue_we = 1'b1;
        commit(5'd7, 32'hAA, 32'h200);
        #1;
        n_checks++; if (bus.D_busy1 !== 1'b1) begin n_fail++; $display("FAIL busy_clear_not_bypassed: got %b expected 1", bus.D_busy1); end
        tick();
        bus.issue_we = 1'b0;
        bus.W_GRF_WE = 1'b0;
        #1;
        n_checks++; if (bus.D_busy1 !== 1'b1) begin n_fail++; $display("FAIL busy_set_wins: got %b expected 1", bus.D_busy1); end
        n_checks++; if (bus.D_GRF_RD1 !== 32'hAA) begin n_fail++; $display("FAIL rd1_x7: got %h expected %h", bus.D_GRF_RD1, 32'hAA); end
        commit(5'd7, 32'hBB, 32'h204);
        tick();
        bus.W_GRF_WE = 1'b0;
        #1;
        n_checks++; if (bus.D_busy1 !== 1'b0) begin n_fail++; $display("FAIL busy_cleared: got %b expected 0", bus.D_busy1); end
        bus.issue_we = 1'b1;
        bus.issue_a3 = 5'd0;
        tick();
        bus.D_GRF_A1 = 5'd0;
        #1;
        n_checks++; if (bus.D_busy1 !== 1'b0) begin n_fail++; $display("FAIL busy_x0: got %b expected 0", bus.D_busy1); end
        bus.issue_a3 = 5'd3;
        tick();
        bus.issue_a3 = 5'd9;
        tick();
        bus.issue_we = 1'b0;
        bus.D_GRF_A1 = 5'd3;
        bus.D_GRF_A2 = 5'd9;
        #1;
        n_checks++; if (bus.D_busy1 !== 1'b1) begin n_fail++; $display("FAIL busy_x3: got %b expected 1", bus.D_busy1); end
        n_checks++; if (bus.D_busy2 !== 1'b1) begin n_fail++; $display("FAIL busy_x9: got %b expected 1", bus.D_busy2); end
        bus.sb_flush = 1'b1;
        bus.issue_we = 1'b1;
        bus.issue_a3 = 5'd3;
        tick();
        bus.sb_flush = 1'b0;
        bus.issue_we = 1'b0;
        #1;
        n_checks++; if (bus.D_busy1 !== 1'b0) begin n_fail++; $display("FAIL flush_over_set: got %b expected 0", bus.D_busy1); end
        n_checks++; if (bus.D_busy2 !== 1'b0) begin n_fail++; $display("FAIL flush_x9: got %b expected 0", bus.D_busy2); end
        idle();
    endtask

`ifdef GRF_TRACE_EN
    task automatic test_full_pop();
        logic [31:0] exp_pc;
        idle();
        drain_trace();
        for (int k = 0; k < 8; k++) begin
            commit(5'(k + 1), 32'(k), 32'h3000 + 32'(4 * k));
            tick();
        end
        bus.W_GRF_WE = 1'b0;
        #1;
        n_checks++; if (bus.trace_ovf !== 1'b0) begin n_fail++; $display("FAIL full8_no_ovf: got %b expected 0", bus.trace_ovf); end
        n_checks++; if (bus.trace_pc !== 32'h3000) begin n_fail++; $display("FAIL full8_head: got %h expected %h", bus.trace_pc, 32'h3000); end
        commit(5'd20, 32'h4000, 32'h4000);
        bus.trace_ready = 1'b1;
        tick();
        bus.trace_ready = 1'b0;
        bus.W_GRF_WE = 1'b0;
        #1;
        n_checks++; if (bus.trace_ovf !== 1'b0) begin n_fail++; $display("FAIL full_pop_no_ovf: got %b expected 0", bus.trace_ovf); end
        n_checks++; if (bus.trace_pc !== 32'h3004) begin n_fail++; $display("FAIL full_pop_head: got %h expected %h", bus.trace_pc, 32'h3004); end
        // count must still be 8, so a lone push now overflows
        commit(5'd21, 32'h5000, 32'h5000);
        tick();
        bus.W_GRF_WE = 1'b0;
        #1;
        n_checks++; if (bus.trace_ovf !== 1'b1) begin n_fail++; $display("FAIL full_pop_count8: got %b expected 1", bus.trace_ovf); end
        bus.trace_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            exp_pc = (k < 7) ? 32'h3004 + 32'(4 * k) : 32'h4000;
            #1;
            n_checks++; if (bus.trace_valid !== 1'b1 || bus.trace_pc !== exp_pc) begin n_fail++; $display("FAIL full_pop_drain%0d: got valid %b pc %h expected pc %h", k, bus.trace_valid, bus.trace_pc, exp_pc); end
            tick();
        end
        bus.trace_ready = 1'b0;
        #1;
        n_checks++; if (bus.trace_valid !== 1'b0) begin n_fail++; $display("FAIL full_pop_empty: got %b expected 0", bus.trace_valid); end
        @(negedge clk) reset_n = 1'b0;
        #1;
        n_checks++; if (bus.trace_ovf !== 1'b0) begin n_fail++; $display("FAIL ovf_reset: got %b expected 0", bus.trace_ovf); end
        @(negedge clk) reset_n = 1'b1;
        tick();
    endtask

    task automatic test_fifo_fill();
        idle();
        for (int k = 0; k < 9; k++) begin
            commit(5'(k + 1), 32'(k), 32'h3000 + 32'(4 * k));
            tick();
            bus.W_GRF_WE = 1'b0;
            #1;
            if (k == 7) begin
                n_checks++; if (bus.trace_ovf !== 1'b0) begin n_fail++; $display("FAIL fill_ovf_8th: got %b expected 0", bus.trace_ovf); end
            end
        end
        n_checks++; if (bus.trace_ovf !== 1'b1) begin n_fail++; $display("FAIL fill_ovf_9th: got %b expected 1", bus.trace_ovf); end
        bus.trace_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            #1;
            n_checks++; if (bus.trace_valid !== 1'b1 || bus.trace_pc !== 32'h3000 + 32'(4 * k) || bus.trace_a3 !== 5'(k + 1)) begin n_fail++; $display("FAIL fill_drain%0d: got valid %b pc %h a3 %0d expected pc %h a3 %0d", k, bus.trace_valid, bus.trace_pc, bus.trace_a3, 32'h3000 + 32'(4 * k), k + 1); end
            tick();
        end
        bus.trace_ready = 1'b0;
        #1;
        n_checks++; if (bus.trace_valid !== 1'b0) begin n_fail++; $display("FAIL fill_empty: got %b expected 0", bus.trace_valid); end
        n_checks++; if (bus.trace_ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky: got %b expected 1", bus.trace_ovf); end
    endtask
`endif

    task automatic test_reset_mid_drain();
        idle();
        commit(5'd5, 32'h55, 32'h600);
        bus.issue_we = 1'b1;
        bus.issue_a3 = 5'd9;
        tick();
        commit(5'd6, 32'h66, 32'h604);
        bus.issue_we = 1'b0;
        tick();
        bus.W_GRF_WE = 1'b0;
        bus.trace_ready = 1'b1;
        tick();
        bus.D_GRF_A1 = 5'd5;
        bus.D_GRF_A2 = 5'd9;
        #1;
        n_checks++; if (bus.D_busy2 !== 1'b1) begin n_fail++; $display("FAIL pre_reset_busy: got %b expected 1", bus.D_busy2); end
        n_checks++; if (bus.D_GRF_RD1 !== 32'h55) begin n_fail++; $display("FAIL pre_reset_rd1: got %h expected %h", bus.D_GRF_RD1, 32'h55); end
        #1 reset_n = 1'b0;
        #1;
        n_checks++; if (bus.trace_valid !== 1'b0) begin n_fail++; $display("FAIL mid_reset_valid: got %b expected 0", bus.trace_valid); end
        n_checks++; if (bus.D_busy2 !== 1'b0) begin n_fail++; $display("FAIL mid_reset_busy: got %b expected 0", bus.D_busy2); end
        n_checks++; if (bus.D_GRF_RD1 !== 32'h0) begin n_fail++; $display("FAIL mid_reset_rd1: got %h expected %h", bus.D_GRF_RD1, 32'h0); end
        n_checks++; if (bus.trace_pc !== 32'h0) begin n_fail++; $display("FAIL mid_reset_trace_pc: got %h expected %h", bus.trace_pc, 32'h0); end
        @(negedge clk) reset_n = 1'b1;
        bus.trace_ready = 1'b0;
        tick();
        n_checks++; if (bus.trace_valid !== 1'b0) begin n_fail++; $display("FAIL post_reset_valid: got %b expected 0", bus.trace_valid); end
        idle();
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset_n  = 1'b1;
        idle();
        test_reset();
        test_write_read();
        test_x0();
        test_scoreboard();
`ifdef GRF_TRACE_EN
        test_full_pop();
        test_fifo_fill();
`endif
        test_reset_mid_drain();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/grf_commit.md
# grf_commit

Architectural general-register file at the far end of the write-back path. It sits between the W stage's write port and the D stage's read ports. It accepts one register write per cycle and serves two combinational reads with write-through bypass. It also keeps a per-register pending-write scoreboard for the hazard unit and can log every commit into a drainable trace FIFO.

## Interface
- `TRACE_DEPTH`, default 8: trace FIFO entries; must be a power of two, at least 2.
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `W_GRF_WE` in 1: write enable from the W stage.
- `W_GRF_A3` in 5: write address.
- `W_GRF_WD` in 32: write data.
- `W_pc` in 32: PC of the committing instruction.
- `D_GRF_A1`, `D_GRF_A2` in 5 each: read addresses.
- `D_GRF_RD1`, `D_GRF_RD2` out 32 each: read data.
- `D_busy1`, `D_busy2` out 1 each: scoreboard bit of A1 / A2.
- `issue_we` in 1: an instruction leaving D will write a register.
- `issue_a3` in 5: its destination register.
- `sb_flush` in 1: clear the whole scoreboard.
- `trace_valid` out 1: FIFO head valid.
- `trace_ready` in 1: drain accepts the head.
- `trace_pc` out 32: head entry PC.
- `trace_a3` out 5: head entry register.
- `trace_wd` out 32: head entry data.
- `trace_ovf` out 1: sticky overflow flag.

## Operation
- **Register array:** 31 physical registers, x1..x31. x0 is not stored and always reads 0.
- **Write:** on an edge with `W_GRF_WE=1` and `A3!=0`, `reg[A3] <= W_GRF_WD`. Writes to x0 are discarded.
- **Read:** `RDn = (An==0) ? 0 : (W_GRF_WE && W_GRF_A3==An) ? W_GRF_WD : reg[An]`.
  - The same-cycle write is bypassed, so W needs no extra forward to D.
- **Scoreboard:** 32-bit `busy`; bit 0 is tied to 0.
  - Set phase: `issue_we && issue_a3!=0` sets `busy[issue_a3]`.
  - Clear phase: `W_GRF_WE && W_GRF_A3!=0` clears `busy[W_GRF_A3]`.
  - Same register in both phases in one cycle: set wins. It belongs to the younger instruction.
  - `sb_flush=1` clears every bit and overrides set and clear in that cycle.
- **Busy outputs:** `D_busyn = busy[An]`, read from current state. This cycle's clear is not bypassed.
- **Trace FIFO**, active only with `GRF_TRACE_EN`:
  - Push: every cycle with `W_GRF_WE=1` pushes {`W_pc`, `W_GRF_A3`, `W_GRF_WD`}. x0 writes are pushed too, because the grader log lists them.
  - Pop: when `trace_valid && trace_ready`.
  - Full, with a pop in the same cycle: push and pop both occur and the count is unchanged.
  - Full, with no pop: the new entry is dropped and `trace_ovf` is set. The flag clears only on reset.
  - Empty, with a push in the same cycle: `trace_valid` rises the next cycle. There is no fall-through.
  - Pointers: `$clog2(TRACE_DEPTH)+1` bits each; wrap is natural modulo.

## Timing
- Reads: zero latency, combinational.
- Register writes, scoreboard updates and FIFO pushes take effect at the next rising edge.
- Trace latency: commit at edge N gives `trace_valid=1` after edge N+1 at the earliest.
- `trace_*` hold stable while `trace_valid && !trace_ready`.
- Reset (asserted asynchronously, at any time, including mid-drain):
  - all registers, `busy`, both pointers and `trace_ovf` go to 0;
  - `trace_valid=0`;
  - `trace_pc`, `trace_a3`, `trace_wd` read 0;
  - `D_GRF_RD*` equal the bypass value or 0.
- Deassertion is taken synchronously by the next edge.

## Configuration
- `GRF_TRACE_EN` defined: trace FIFO and overflow flag are present, as described above.
- `GRF_TRACE_EN` undefined: no FIFO storage is built.
  - `trace_valid`, `trace_ovf`, `trace_pc`, `trace_a3` and `trace_wd` are tied to 0.
  - `trace_ready` is ignored.
  - Register, bypass and scoreboard behaviour is identical in both builds.

## Structure
- **Shared package:**
  - `GRF_ZERO` (5'd0);
  - trace entry width constant `TRACE_W` = 69;
  - trace entry packing offsets.
- **Sub-module `grf_trace_fifo`:** synchronous FIFO with `DEPTH` and `WIDTH` parameters, push/pop, `valid`, and a sticky `ovf`. It is instantiated only under `GRF_TRACE_EN`.

## Test plan
- **Write then read:** reset, write x5=0x1234_5678, then read A1=5 the next cycle -> RD1=0x12345678. A same-cycle read with A2=5 -> RD2 is the bypassed value.
- **x0 protection:** write x0=0xFFFF_FFFF with A1=0 -> RD1=0 in the same and the following cycle. The trace head shows a3=0 and wd=0xFFFFFFFF.
- **Scoreboard:**
  - issue x7 -> `D_busy1`=1 for A1=7 the next cycle;
  - issue x7 and write back x7 in the same cycle -> busy stays 1;
  - a later writeback alone -> busy 0;
  - `sb_flush` -> all 0.
- **FIFO fill:** depth 8, `trace_ready=0`, 9 commits with pc 0x3000+4k -> `trace_ovf`=1 after the 9th. Draining yields exactly pcs 0x3000..0x301C in order.
- **Full with pop:** full FIFO with a push and pop in the same cycle -> no overflow, count stays 8, head advances by one.
- **Reset mid-drain:** assert `reset_n`=0 asynchronously mid-drain -> `trace_valid`=0 and `busy`=0 immediately; reading x5 -> 0.
